// File: rtl/row_decoder_seq.sv
// Sequenced row decoder: drives one registered one-hot row for PULSE_CYC
// cycles, then holds all rows low for GAP_CYC cycles. Rows come either from
// a valid/ready request or from an auto-scan sweep over every row.
module row_decoder_seq #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    scan_en,
    output logic [(1<<ADDR_W)-1:0]  rows,
    output logic [ADDR_W-1:0]       cur_row,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ROWS     = 1 << ADDR_W;
    localparam int unsigned MAX_CYC  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   row_d;
    logic [ROWS-1:0]     rows_d;
    logic                done_d;
    logic                busy_d;
    logic                row_end;

    // Accept requests only while idle and not scanning.
    assign req_ready = (state_q == IDLE) && !scan_en;

    // Next-state, counter, row and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = cur_row;
        done_d  = 1'b0;
        row_end = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    row_d   = req_addr;
                    cnt_d   = PULSE_LD;
                    state_d = DRIVE;
                end else if (scan_en) begin
                    row_d   = '0;
                    cnt_d   = PULSE_LD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q <= CNT_ONE) begin
                    done_d = 1'b1;
                    if (GAP_CYC > 0) begin
                        cnt_d   = GAP_LD;
                        state_d = GAP;
                    end else begin
                        row_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q <= CNT_ONE) begin
                    row_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A finished row either chains into the next scan row or returns idle.
        if (row_end) begin
            if (scan_en) begin
                row_d   = cur_row + ADDR_W'(1);
                cnt_d   = PULSE_LD;
                state_d = DRIVE;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end

        rows_d = (state_d == DRIVE) ? (ROWS'(1) << row_d) : '0;
        busy_d = (state_d == DRIVE) || (state_d == GAP);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_row <= '0;
            rows    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_row <= row_d;
            rows    <= rows_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_row_decoder_seq.sv
// Bench for row_decoder_seq: four instances (default, fast scan, narrow and
// wide sweeps) checked every cycle against a timeline model, plus a vector
// table and directed multi-cycle sequences.
module tb_row_decoder_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] v, s;
    logic [5:0] a [4];

    wire [3:0]  rdy, busy, done;
    wire [7:0]  rows0, rows1;
    wire [1:0]  rows2;
    wire [63:0] rows3;
    wire [2:0]  cur0, cur1;
    wire [0:0]  cur2;
    wire [5:0]  cur3;

    row_decoder_seq #(.ADDR_W(3), .PULSE_CYC(2), .GAP_CYC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_addr(a[0][2:0]), .scan_en(s[0]), .rows(rows0), .cur_row(cur0),
        .busy(busy[0]), .done(done[0]));
    row_decoder_seq #(.ADDR_W(3), .PULSE_CYC(1), .GAP_CYC(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[1]), .req_ready(rdy[1]),
        .req_addr(a[1][2:0]), .scan_en(s[1]), .rows(rows1), .cur_row(cur1),
        .busy(busy[1]), .done(done[1]));
    row_decoder_seq #(.ADDR_W(1), .PULSE_CYC(4), .GAP_CYC(3)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[2]), .req_ready(rdy[2]),
        .req_addr(a[2][0:0]), .scan_en(s[2]), .rows(rows2), .cur_row(cur2),
        .busy(busy[2]), .done(done[2]));
    row_decoder_seq #(.ADDR_W(6), .PULSE_CYC(4), .GAP_CYC(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[3]), .req_ready(rdy[3]),
        .req_addr(a[3][5:0]), .scan_en(s[3]), .rows(rows3), .cur_row(cur3),
        .busy(busy[3]), .done(done[3]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    // Timeline model: a row started at cycle 'start' is driven for p cycles,
    // idles the rows for g cycles, and reports done at start+p.
    typedef struct {
        bit active;
        int start;
        int addr;
        int done_at;
        int prev_done;
    } mdl_t;

    int   pw [4] = '{2, 1, 4, 4};
    int   gw [4] = '{1, 0, 3, 3};
    int   rw [4] = '{8, 8, 2, 64};
    mdl_t m  [4];
    int   cyc = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.active = 1'b0; r.start = 0; r.addr = 0; r.done_at = -1; r.prev_done = -1;
        return r;
    endfunction

    function automatic mdl_t mdl_start(input mdl_t mi, input int n1, input int addr, input int p);
        mdl_t r = mi;
        r.active = 1'b1; r.start = n1; r.addr = addr;
        r.prev_done = mi.done_at; r.done_at = n1 + p;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t mi, input int n1, input bit vi, input int ai,
                                      input bit si, input int p, input int g, input int r);
        mdl_t mo = mi;
        if (mi.active && n1 == mi.start + p + g) begin
            if (si) mo = mdl_start(mi, n1, (mi.addr + 1) % r, p);
            else    mo.active = 1'b0;
        end else if (!mi.active) begin
            if (vi && !si)  mo = mdl_start(mi, n1, ai % r, p);
            else if (si)    mo = mdl_start(mi, n1, 0, p);
        end
        return mo;
    endfunction

    logic [63:0] ro [4];
    logic [63:0] co [4];
    logic [63:0] rexp;
    logic [63:0] one64 = 64'd1;

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        ro[0] = 64'(rows0); ro[1] = 64'(rows1); ro[2] = 64'(rows2); ro[3] = rows3;
        co[0] = 64'(cur0);  co[1] = 64'(cur1);  co[2] = 64'(cur2);  co[3] = 64'(cur3);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) m[i] = mdl_reset();
            rexp = (m[i].active && (cyc - m[i].start) < pw[i]) ? (one64 << m[i].addr) : 64'd0;
            chk($sformatf("u%0d.rows", i), ro[i], rexp);
            chk($sformatf("u%0d.busy", i), 64'(busy[i]), 64'(m[i].active));
            chk($sformatf("u%0d.done", i), 64'(done[i]),
                64'((cyc == m[i].done_at) || (cyc == m[i].prev_done)));
            chk($sformatf("u%0d.cur_row", i), co[i], 64'(m[i].addr));
            chk($sformatf("u%0d.req_ready", i), 64'(rdy[i]), 64'(!m[i].active && !s[i]));
            if (i >= 2) chk($sformatf("u%0d.onehot", i), 64'($countones(ro[i]) <= 1), 64'd1);
            if (rst_n) m[i] = mdl_step(m[i], cyc + 1, v[i], int'(a[i]), s[i], pw[i], gw[i], rw[i]);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        v = '0;
        s = '0;
        for (int i = 0; i < 4; i++) a[i] = '0;
    endtask

    typedef struct {
        bit         v;
        logic [2:0] a;
        logic [7:0] rows;
        bit         done;
        bit         ready;
        bit         busy;
    } vec_t;

    vec_t       tbl [14];
    int         dc;
    bit         found;
    logic [7:0] one8 = 8'd1;

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < 4; i++) m[i] = mdl_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // Single access addr 5, then back-to-back 0 and 7 with valid held high.
        tbl[0]  = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 8'h20, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 3'd0, 8'h20, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            v[0] = tbl[i].v;
            a[0] = 6'(tbl[i].a);
            @(negedge clk);
            chk($sformatf("tbl%0d.rows", i),  64'(rows0),   64'(tbl[i].rows));
            chk($sformatf("tbl%0d.done", i),  64'(done[0]), 64'(tbl[i].done));
            chk($sformatf("tbl%0d.ready", i), 64'(rdy[0]),  64'(tbl[i].ready));
            chk($sformatf("tbl%0d.busy", i),  64'(busy[0]), 64'(tbl[i].busy));
            tick();
        end
        idle_all();
        repeat (2) tick();

        // Asynchronous reset in the first DRIVE cycle of a pulse.
        v[0] = 1'b1; a[0] = 6'd2;
        tick();
        v[0] = 1'b0;
        chk("rst.pre_rows", 64'(rows0), 64'h04);
        rst_n = 1'b0;
        #1;
        chk("rst.rows", 64'(rows0), 64'd0);
        chk("rst.busy", 64'(busy[0]), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            dc += int'(done[0]);
            tick();
        end
        chk("rst.no_done", 64'(dc), 64'd0);

        // Fast scan with no gap: one new row per cycle, wrapping at row 7.
        s[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("scan%0d.rows", k), 64'(rows1), 64'(one8 << (k % 8)));
            if (k >= 1) chk($sformatf("scan%0d.done", k), 64'(done[1]), 64'd1);
            chk($sformatf("scan%0d.ready", k), 64'(rdy[1]), 64'd0);
        end
        tick();
        s[1] = 1'b0;
        repeat (3) tick();

        // Drop scan during row 3, with a request pending throughout.
        s[0] = 1'b1; v[0] = 1'b1; a[0] = 6'd6;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (cur0 == 3'd3 && rows0 != 8'd0) found = 1'b1;
        end
        chk("drop.reach_row3", 64'(found), 64'd1);
        tick();
        s[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (!busy[0]) found = 1'b1;
        end
        chk("drop.reach_idle", 64'(found), 64'd1);
        chk("drop.cur_row", 64'(cur0), 64'd3);
        chk("drop.ready", 64'(rdy[0]), 64'd1);
        tick();
        @(negedge clk);
        chk("drop.accept_cur", 64'(cur0), 64'd6);
        chk("drop.accept_rows", 64'(rows0), 64'h40);
        tick();
        idle_all();
        repeat (6) tick();

        // Random traffic on all instances, scan enable held for stretches.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) s[i] = ~s[i];
                v[i] = ($urandom_range(0, 2) != 0);
                a[i] = 6'($urandom);
            end
            tick();
        end
        idle_all();
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
